// File: rtl/ila_capture_ctrl.sv
// rtl/ila_capture_ctrl.sv - arm/trigger/holdoff/readout sequencer for one logic analyzer capture core
module ila_capture_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int HOLDOFF_WIDTH = 4,
    parameter int DEPTH         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic [DATA_WIDTH-1:0]    i_trig_mask,
    input  logic [DATA_WIDTH-1:0]    i_trig_value,
    input  logic                     i_trig_edge,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic [DATA_WIDTH-1:0]    i_probe,
    input  logic                     i_core_primed,
    input  logic [DATA_WIDTH-1:0]    i_core_data,
    output logic                     o_core_reset,
    output logic                     o_core_trigger,
    output logic [HOLDOFF_WIDTH-1:0] o_core_holdoff,
    output logic                     o_core_rd,
    output logic                     m_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [2:0]               o_state,
    output logic                     o_busy
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int HC_W  = HOLDOFF_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_READ = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state, state_n;

    // rearm: an i_arm seen in DONE passes through one IDLE cycle (core reset) then ARM
    logic                  rearm;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic                  edge_q;
    logic                  prev_match;
    logic                  match;
    logic                  fire;
    logic                  issue;
    logic                  arm_take;
    logic [HC_W-1:0]       hold_cnt;
    logic                  cap_pending;
    logic [CNT_W-1:0]      issued_cnt;
    logic [CNT_W-1:0]      cap_cnt;

    assign o_state = state;

    // next state, trigger evaluation and read-issue decision
    always_comb begin
        state_n  = state;
        fire     = 1'b0;
        issue    = 1'b0;
        arm_take = 1'b0;
        match    = ((i_probe ^ value_q) & mask_q) == '0;
        case (state)
            S_IDLE: begin
                arm_take = i_arm;
                if (rearm || i_arm) state_n = S_ARM;
            end
            S_ARM: begin
                if (i_core_primed) state_n = S_WAIT;
            end
            S_WAIT: begin
                fire = edge_q ? (match && !prev_match) : match;
                if (fire) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HC_W'(1)) state_n = S_READ;
            end
            S_READ: begin
                // one word in flight at most; never advance the core while a word is stalled
                issue = !o_core_rd && !cap_pending && (!m_valid || m_ready) &&
                        (issued_cnt < CNT_W'(DEPTH));
                if (m_valid && m_ready && m_last) state_n = S_DONE;
            end
            S_DONE: begin
                if (i_arm) begin
                    arm_take = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (i_abort) begin
            state_n  = S_IDLE;
            issue    = 1'b0;
            arm_take = 1'b0;
        end
    end

    // state register, latched trigger setup, holdoff counter and core control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            rearm          <= 1'b0;
            mask_q         <= '0;
            value_q        <= '0;
            edge_q         <= 1'b0;
            prev_match     <= 1'b0;
            hold_cnt       <= '0;
            o_core_reset   <= 1'b1;
            o_core_trigger <= 1'b0;
            o_core_holdoff <= '0;
            o_busy         <= 1'b0;
        end else begin
            state          <= state_n;
            rearm          <= arm_take && (state == S_DONE);
            o_core_reset   <= (state_n == S_IDLE);
            o_core_trigger <= (state_n == S_HOLD) || (state_n == S_READ) || (state_n == S_DONE);
            o_busy         <= (state_n != S_IDLE) && (state_n != S_DONE);
            if (arm_take) begin
                mask_q         <= i_trig_mask;
                value_q        <= i_trig_value;
                edge_q         <= i_trig_edge;
                o_core_holdoff <= i_holdoff;
            end
            // entering WAIT counts as "match already high" so a standing match needs a fresh rise
            if (state_n == S_WAIT) prev_match <= (state == S_WAIT) ? match : 1'b1;
            if (state_n == S_HOLD) begin
                hold_cnt <= (state == S_HOLD) ? hold_cnt - HC_W'(1)
                                              : HC_W'(o_core_holdoff) + HC_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // readout pipeline: read strobe, core latency cycle, then the stream output register
    always_ff @(posedge clk) begin
        if (reset || state_n != S_READ) begin
            o_core_rd   <= 1'b0;
            cap_pending <= 1'b0;
            issued_cnt  <= '0;
            cap_cnt     <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            if (reset) m_data <= '0;
        end else begin
            o_core_rd   <= issue;
            cap_pending <= o_core_rd;
            if (issue) issued_cnt <= issued_cnt + CNT_W'(1);
            if (cap_pending) begin
                m_data  <= i_core_data;
                m_valid <= 1'b1;
                m_last  <= (cap_cnt == CNT_W'(DEPTH - 1));
                cap_cnt <= cap_cnt + CNT_W'(1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb/tb_ila_capture_ctrl.sv - directed self-checking bench for ila_capture_ctrl
module tb_ila_capture_ctrl;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_arm = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_trig_mask = 8'h00;
    logic [7:0] i_trig_value = 8'h00;
    logic       i_trig_edge = 1'b0;
    logic [3:0] i_holdoff = 4'h0;
    logic [7:0] i_probe = 8'h00;
    logic       i_core_primed;
    logic [7:0] i_core_data = 8'h00;
    logic       o_core_reset;
    logic       o_core_trigger;
    logic [3:0] o_core_holdoff;
    logic       o_core_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b0;
    logic [2:0] o_state;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [DEPTH];
    logic [3:0] ptr = 4'd0;
    int         fill = 0;

    ila_capture_ctrl #(.DATA_WIDTH(8), .HOLDOFF_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value), .i_trig_edge(i_trig_edge),
        .i_holdoff(i_holdoff), .i_probe(i_probe), .i_core_primed(i_core_primed),
        .i_core_data(i_core_data), .o_core_reset(o_core_reset), .o_core_trigger(o_core_trigger),
        .o_core_holdoff(o_core_holdoff), .o_core_rd(o_core_rd), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .o_state(o_state), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // capture core model: fills for DEPTH cycles after reset release, reads with 1-cycle latency
    always @(posedge clk) begin
        if (o_core_reset !== 1'b0) begin
            ptr  <= 4'd0;
            fill <= 0;
        end else begin
            if (fill < DEPTH) fill <= fill + 1;
            if (o_core_rd === 1'b1) begin
                i_core_data <= mem[ptr];
                ptr         <= ptr + 4'd1;
            end
        end
    end
    assign i_core_primed = (fill >= DEPTH);

    task automatic fill_mem(input int seed, input int step);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(seed + i * step);
    endtask

    task automatic do_reset();
        reset = 1'b1; i_arm = 1'b0; i_abort = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_arm();
        i_arm = 1'b1;
        @(negedge clk);
        i_arm = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, output int n);
        n = 0;
        while (o_state !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_to_read(output int n);
        n = 0;
        while (o_state !== 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic read_words(input bit rnd, input int stop_at, output int got);
        logic       stalled;
        logic [7:0] held;
        got = 0; stalled = 1'b0; held = 8'h00;
        for (int cyc = 0; cyc < 800 && got < DEPTH; cyc++) begin
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold word %0d got valid=%b data=%h exp valid=1 data=%h", got, m_valid, m_data, held);
                end
                checks++;
                if (o_core_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_while_stalled word %0d got %b exp 0", got, o_core_rd);
                end
            end
            if (m_valid === 1'b1 && got == stop_at) begin
                m_ready = 1'b0;
                break;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid === 1'b1) begin
                if (m_ready) begin
                    checks++;
                    if (m_data !== mem[got]) begin
                        errors++;
                        $display("FAIL word_data %0d got %h exp %h", got, m_data, mem[got]);
                    end
                    checks++;
                    if (m_last !== (got == DEPTH - 1)) begin
                        errors++;
                        $display("FAIL word_last %0d got %b exp %b", got, m_last, (got == DEPTH - 1));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = m_data;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        if (stop_at < 0) m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", o_state); end
        checks++; if (o_core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %b exp 1", o_core_reset); end
        checks++; if (o_core_trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %b exp 0", o_core_trigger); end
        checks++; if (o_core_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", o_core_rd); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_stream got valid=%b last=%b exp 0 0", m_valid, m_last); end
        checks++; if (o_core_holdoff !== 4'h0) begin errors++; $display("FAIL reset_holdoff got %h exp 0", o_core_holdoff); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        reset = 1'b0;
    endtask

    task automatic test_level_ramp();
        int n; int fired; int got;
        do_reset();
        fill_mem(8'h21, 37);
        i_trig_mask = 8'hFF; i_trig_value = 8'hA5; i_trig_edge = 1'b0; i_holdoff = 4'd3; i_probe = 8'h00;
        pulse_arm();
        checks++; if (o_state !== 3'd1 || o_busy !== 1'b1 || o_core_reset !== 1'b0) begin errors++; $display("FAIL ramp_arm got state=%0d busy=%b rst=%b exp 1 1 0", o_state, o_busy, o_core_reset); end
        wait_state(3'd2, n);
        checks++; if (n >= 200) begin errors++; $display("FAIL ramp_wait_timeout got %0d exp <200", n); end
        fired = -1;
        for (int p = 0; p < 256; p++) begin
            i_probe = 8'(p);
            @(negedge clk);
            if (o_core_trigger === 1'b1) begin fired = p; break; end
        end
        checks++; if (fired != 8'hA5) begin errors++; $display("FAIL ramp_fire_probe got %0h exp a5", fired); end
        checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL ramp_hold got %0d exp 3", o_state); end
        count_to_read(n);
        checks++; if (n != 4) begin errors++; $display("FAIL ramp_hold_cycles got %0d exp 4", n); end
        read_words(1'b0, -1, got);
        checks++; if (got != DEPTH) begin errors++; $display("FAIL ramp_words got %0d exp %0d", got, DEPTH); end
        checks++; if (o_state !== 3'd5 || o_busy !== 1'b0) begin errors++; $display("FAIL ramp_done got state=%0d busy=%b exp 5 0", o_state, o_busy); end
        checks++; if (o_core_trigger !== 1'b1 || o_core_reset !== 1'b0) begin errors++; $display("FAIL done_core_hold got trig=%b rst=%b exp 1 0", o_core_trigger, o_core_reset); end
    endtask

    task automatic test_edge();
        int n; bit early;
        do_reset();
        i_trig_mask = 8'hFF; i_trig_value = 8'hA5; i_trig_edge = 1'b1; i_holdoff = 4'd2; i_probe = 8'hA5;
        pulse_arm();
        wait_state(3'd2, n);
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_core_trigger !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin errors++; $display("FAIL edge_standing_match got trigger=1 exp 0"); end
        i_probe = 8'h00;
        @(negedge clk);
        checks++; if (o_core_trigger !== 1'b0 || o_state !== 3'd2) begin errors++; $display("FAIL edge_low got trig=%b state=%0d exp 0 2", o_core_trigger, o_state); end
        i_probe = 8'hA5;
        @(negedge clk);
        checks++; if (o_core_trigger !== 1'b1 || o_state !== 3'd3) begin errors++; $display("FAIL edge_rise got trig=%b state=%0d exp 1 3", o_core_trigger, o_state); end
        i_trig_edge = 1'b0;
    endtask

    task automatic test_mask0_random_ready();
        int n; int got;
        do_reset();
        fill_mem(8'h5A, 11);
        i_trig_mask = 8'h00; i_trig_value = 8'h3C; i_holdoff = 4'd0; i_probe = 8'h77;
        pulse_arm();
        wait_state(3'd2, n);
        checks++; if (o_core_trigger !== 1'b0) begin errors++; $display("FAIL mask0_first_wait got trig=%b exp 0", o_core_trigger); end
        @(negedge clk);
        checks++; if (o_core_trigger !== 1'b1 || o_state !== 3'd3) begin errors++; $display("FAIL mask0_fire got trig=%b state=%0d exp 1 3", o_core_trigger, o_state); end
        @(negedge clk);
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL holdoff0_read got %0d exp 4", o_state); end
        read_words(1'b1, -1, got);
        checks++; if (got != DEPTH) begin errors++; $display("FAIL rnd_words got %0d exp %0d", got, DEPTH); end
        checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL rnd_done got %0d exp 5", o_state); end
    endtask

    task automatic test_rearm();
        int n; int got;
        fill_mem(8'hF0, 13);
        i_trig_mask = 8'hFF; i_trig_value = 8'h10; i_holdoff = 4'd5; i_probe = 8'h10;
        pulse_arm();
        checks++; if (o_state !== 3'd0 || o_core_reset !== 1'b1 || o_core_trigger !== 1'b0) begin errors++; $display("FAIL rearm_reset got state=%0d rst=%b trig=%b exp 0 1 0", o_state, o_core_reset, o_core_trigger); end
        @(negedge clk);
        checks++; if (o_state !== 3'd1 || o_core_reset !== 1'b0) begin errors++; $display("FAIL rearm_arm got state=%0d rst=%b exp 1 0", o_state, o_core_reset); end
        checks++; if (o_core_holdoff !== 4'd5) begin errors++; $display("FAIL rearm_holdoff got %0d exp 5", o_core_holdoff); end
        wait_state(3'd2, n);
        @(negedge clk);
        checks++; if (o_core_trigger !== 1'b1) begin errors++; $display("FAIL rearm_fire got %b exp 1", o_core_trigger); end
        count_to_read(n);
        checks++; if (n != 6) begin errors++; $display("FAIL rearm_hold_cycles got %0d exp 6", n); end
        read_words(1'b0, -1, got);
        checks++; if (got != DEPTH || o_state !== 3'd5) begin errors++; $display("FAIL rearm_words got %0d state=%0d exp %0d 5", got, o_state, DEPTH); end
        i_arm = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_arm = 1'b0; i_abort = 1'b0;
        @(negedge clk);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL abort_over_arm got %0d exp 0", o_state); end
    endtask

    task automatic test_abort_hold();
        int n;
        do_reset();
        i_trig_mask = 8'h00; i_holdoff = 4'd7;
        pulse_arm();
        wait_state(3'd3, n);
        i_holdoff = 4'd2;
        pulse_arm();
        checks++; if (o_state !== 3'd3 || o_core_holdoff !== 4'd7) begin errors++; $display("FAIL arm_while_busy got state=%0d hold=%0d exp 3 7", o_state, o_core_holdoff); end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++; if (o_state !== 3'd0 || o_core_reset !== 1'b1 || o_core_trigger !== 1'b0 || o_busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL abort_hold got state=%0d rst=%b trig=%b busy=%b valid=%b exp 0 1 0 0 0", o_state, o_core_reset, o_core_trigger, o_busy, m_valid);
        end
    endtask

    task automatic test_abort_read();
        int n; int got;
        do_reset();
        fill_mem(8'h02, 3);
        i_trig_mask = 8'h00; i_holdoff = 4'd0;
        pulse_arm();
        wait_state(3'd4, n);
        read_words(1'b0, 7, got);
        checks++; if (got != 7 || m_valid !== 1'b1) begin errors++; $display("FAIL abort_read_setup got %0d valid=%b exp 7 1", got, m_valid); end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++; if (o_state !== 3'd0 || m_valid !== 1'b0 || o_core_reset !== 1'b1 || o_core_rd !== 1'b0) begin
            errors++; $display("FAIL abort_read got state=%0d valid=%b rst=%b rd=%b exp 0 0 1 0", o_state, m_valid, o_core_reset, o_core_rd);
        end
        pulse_arm();
        wait_state(3'd3, n);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (o_state !== 3'd0 || o_core_reset !== 1'b1 || o_core_trigger !== 1'b0) begin errors++; $display("FAIL reset_mid got state=%0d rst=%b trig=%b exp 0 1 0", o_state, o_core_reset, o_core_trigger); end
    endtask

    initial begin
        fill_mem(0, 1);
        test_reset();
        test_level_ramp();
        test_edge();
        test_mask0_random_ready();
        test_rearm();
        test_abort_hold();
        test_abort_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
